// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared ALU definitions for the Booth multiplier and the sequential divider.
package cpu_alu_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_SIGN, DIV_DONE} div_state_t;
    localparam logic HS_ON = 1'b1;
    localparam logic HS_OFF = 1'b0;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on (P, Q, |divisor|).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   d,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] sp;
    logic ge;
    assign sp = {p, q[WIDTH-1]};
    assign ge = sp >= d;
    // P stays below |divisor| <= 2^(WIDTH-1), so the difference always fits WIDTH bits
    assign p_next = ge ? sp[WIDTH-1:0] - d[WIDTH-1:0] : sp[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider, one quotient bit per clock.
// DIV_ZERO_TRAP_EN adds the div_zero output and a short path for a zero divisor.
module seq_divider
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic             div_zero
`endif
);
    localparam int CW = $clog2(WIDTH);
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    div_state_t state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] p, q, p_next, q_next, amag, bmag, rsrc;
    logic [WIDTH:0] dmag;
    logic sign_q, sign_r, zero;
    assign amag = dividend[WIDTH-1] ? -dividend : dividend;
    assign bmag = divisor[WIDTH-1] ? -divisor : divisor;
    // a trapped zero divisor never runs, so Q still holds |dividend|
    assign rsrc = (TRAP && zero) ? q : p;
    div_step #(.WIDTH(WIDTH)) u_step (
        .p(p),
        .q(q),
        .d(dmag),
        .p_next(p_next),
        .q_next(q_next)
    );
    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            state <= DIV_IDLE;
            busy <= HS_OFF;
            done <= HS_OFF;
            quotient <= '0;
            remainder <= '0;
            p <= '0;
            q <= '0;
            dmag <= '0;
            count <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zero <= 1'b0;
        end else
            case (state)
                DIV_RUN: begin
                    p <= p_next;
                    q <= q_next;
                    count <= count - 1'b1;
                    if (count == '0) state <= DIV_SIGN;
                end
                DIV_SIGN: begin
                    quotient <= zero ? (TRAP ? '0 : q) : (sign_q ? -q : q);
                    remainder <= sign_r ? -rsrc : rsrc;
                    done <= HS_ON;
                    state <= DIV_DONE;
                end
                // DONE accepts a new start on the same edge that drops done
                default: begin
                    done <= HS_OFF;
                    if (start) begin
                        p <= '0;
                        q <= amag;
                        dmag <= {1'b0, bmag};
                        sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r <= dividend[WIDTH-1];
                        zero <= divisor == '0;
                        count <= CW'(WIDTH - 1);
                        busy <= HS_ON;
                        state <= (TRAP && divisor == '0) ? DIV_SIGN : DIV_RUN;
                    end else begin
                        busy <= HS_OFF;
                        state <= DIV_IDLE;
                    end
                end
            endcase
`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge clr)
        if (!clr) div_zero <= 1'b0;
        else if (start && (state == DIV_IDLE || state == DIV_DONE)) div_zero <= 1'b0;
        else if (state == DIV_SIGN) div_zero <= zero;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboard checks for seq_divider (optionally with DIV_ZERO_TRAP_EN).
module tb_seq_divider;
    localparam int W = 32;
    logic clk = 1'b0, clr = 1'b0, start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic busy, done;
    logic [W-1:0] quotient, remainder;
`ifdef DIV_ZERO_TRAP_EN
    logic div_zero;
`endif
    typedef struct {logic [W-1:0] a, b, q, r;} vec_t;
    typedef struct {logic [W-1:0] q, r; logic dz;} exp_t;
    exp_t sb[$];
    vec_t tbl[12];
    int tests = 0, fails = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .clr(clr),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder)
`ifdef DIV_ZERO_TRAP_EN
        ,
        .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q;
        e.r = r;
        e.dz = dz;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic dz);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        push(q, r, dz);
    endtask

    // counts negedges until done; lat is the expected count and busy-high count
    task automatic wait_done(input int lat, input bit keep);
        int n = 0, bc = 0;
        bit got = 1'b0;
        exp_t e;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (!keep) start = 1'b0;
            if (busy) bc++;
            got = done;
        end
        chk("done_seen", W'(got), W'(1));
        chk("latency", W'(n), W'(lat));
        chk("busy_cycles", W'(bc), W'(lat));
        if (got) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: done with no expected entry");
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
`ifdef DIV_ZERO_TRAP_EN
                chk("div_zero", W'(div_zero), W'(e.dz));
`endif
            end
        end
        if (!keep) begin
            @(negedge clk);
            chk("done_pulse", W'(done), W'(0));
            chk("busy_fall", W'(busy), W'(0));
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        tbl[0] = '{32'd7, 32'd2, 32'd3, 32'd1};
        tbl[1] = '{-32'sd7, 32'd2, -32'sd3, -32'sd1};
        tbl[2] = '{32'd7, -32'sd2, -32'sd3, 32'd1};
        tbl[3] = '{-32'sd7, -32'sd2, 32'd3, -32'sd1};
        tbl[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        tbl[5] = '{32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0};
        tbl[6] = '{32'd100, 32'd7, 32'd14, 32'd2};
        tbl[7] = '{32'h80000000, 32'd3, 32'hD5555556, 32'hFFFFFFFE};
        for (int i = 8; i < 12; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 30);
            if (b == '0) b = 32'd1;
            if ($urandom_range(0, 1) == 1) b = -b;
            if (a == 32'h80000000) a = 32'd1;
            tbl[i].a = a;
            tbl[i].b = b;
            tbl[i].q = W'($signed(a) / $signed(b));
            tbl[i].r = W'($signed(a) % $signed(b));
        end
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b0);
            wait_done(34, 1'b0);
        end
        // start held high with new operands during RUN: first result unaffected, second starts at E34
        drive(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        dividend = 32'd50;
        divisor = 32'd5;
        push(32'd10, 32'd0, 1'b0);
        wait_done(33, 1'b1);
        wait_done(34, 1'b0);
        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_mid_run", W'(busy), W'(1));
        clr = 1'b0;
        #1;
        chk("clr_busy", W'(busy), W'(0));
        chk("clr_done", W'(done), W'(0));
        chk("clr_quotient", quotient, '0);
        chk("clr_remainder", remainder, '0);
        @(negedge clk);
        clr = 1'b1;
        drive(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_done(34, 1'b0);
        // zero divisor
`ifdef DIV_ZERO_TRAP_EN
        drive(-32'sd5, 32'd0, 32'd0, -32'sd5, 1'b1);
        wait_done(2, 1'b0);
`else
        drive(-32'sd5, 32'd0, 32'hFFFFFFFF, -32'sd5, 1'b0);
        wait_done(34, 1'b0);
`endif
        drive(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        wait_done(34, 1'b0);
        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
